// File: rtl/stim_mem_reader_pkg.sv
// Shared types and defaults for the stimulus-memory read master.
// Optional output gain stage is enabled by defining STIM_MEM_READER_GAIN_EN.
package stim_mem_reader_pkg;

  localparam int AW_DEF   = 10;
  localparam int DW_DEF   = 32;
  localparam int INCW_DEF = 8;

  // 8.8 unsigned gain that leaves samples unchanged
  localparam logic [15:0] UNITY_GAIN = 16'h0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage : stim_mem_reader_pkg

// File: rtl/stim_mem_reader_if.sv
// Memory read port plus sample stream seen by the stimulus-memory reader.
// master = the reader, slave = memory-merge stage and waveform core together.
interface stim_mem_reader_if
  import stim_mem_reader_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          csb_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] dout_i;
  logic          tvalid_o;
  logic          tready_i;
  logic [DW-1:0] tdata_o;
  logic          busy_o;

  modport master (
    output csb_o, addr_o, tvalid_o, tdata_o, busy_o,
    input  dout_i, tready_i
  );

  modport slave (
    input  csb_o, addr_o, tvalid_o, tdata_o, busy_o,
    output dout_i, tready_i
  );

endinterface : stim_mem_reader_if

// File: rtl/stim_mem_addr_gen.sv
// Window address pointer: loads the window start and steps by cfg_inc,
// wrapping to the start when the next step would pass the inclusive end.
module stim_mem_addr_gen
  import stim_mem_reader_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int INCW = INCW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            advance,
  input  logic [AW-1:0]   cfg_start,
  input  logic [AW-1:0]   cfg_end,
  input  logic [INCW-1:0] cfg_inc,
  output logic [AW-1:0]   ptr
);

  logic [AW:0]   sum;
  logic          wrap;
  logic [AW-1:0] ptr_next;

  // One extra bit so a step past 2^AW-1 is seen as beyond the end, never as a wrap to 0
  assign sum      = {1'b0, ptr} + {{(AW + 1 - INCW){1'b0}}, cfg_inc};
  assign wrap     = (sum > {1'b0, cfg_end}) || (ptr >= cfg_end);
  assign ptr_next = wrap ? cfg_start : sum[AW-1:0];

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= cfg_start;
    end else if (advance) begin
      ptr <= ptr_next;
    end
  end

endmodule : stim_mem_addr_gen

// File: rtl/stim_mem_reader.sv
// Sequential read master for the merged stimulus memory: walks a window and
// streams words out. Define STIM_MEM_READER_GAIN_EN for the saturating 8.8 gain.
module stim_mem_reader
  import stim_mem_reader_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int INCW = INCW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_en_i,
  input  logic [AW-1:0]   cfg_start_i,
  input  logic [AW-1:0]   cfg_end_i,
  input  logic [INCW-1:0] cfg_inc_i,
`ifdef STIM_MEM_READER_GAIN_EN
  input  logic [15:0]     cfg_gain_i,
`endif
  stim_mem_reader_if.master bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr;
  logic [AW-1:0] addr_q;
  logic          tvalid_q;
  logic [DW-1:0] tdata_q;
  logic [DW-1:0] sample_d;
  logic          handshake;

  assign handshake = tvalid_q & bus.tready_i;

  stim_mem_addr_gen #(
    .AW   (AW),
    .INCW (INCW)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      ((state_q == IDLE) && cfg_en_i),
    .advance   ((state_q == WAIT) && cfg_en_i),
    .cfg_start (cfg_start_i),
    .cfg_end   (cfg_end_i),
    .cfg_inc   (cfg_inc_i),
    .ptr       (ptr)
  );

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  // NOTE: every always_comb output gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (!cfg_en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = WAIT;
        WAIT:    state_d = HOLD;
        HOLD:    if (handshake) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  // The merge stage selects the dout bank from the live address, so the address
  // presented in REQ is latched and held through WAIT and HOLD.
  always_comb begin
    bus.csb_o  = 1'b1;
    bus.addr_o = addr_q;
    bus.busy_o = (state_q != IDLE);
    if (state_q == REQ) begin
      bus.csb_o  = 1'b0;
      bus.addr_o = ptr;
    end
  end

  assign bus.tvalid_o = tvalid_q;
  assign bus.tdata_o  = tdata_q;

  // ---------------------------------------------------------------- sample path
`ifdef STIM_MEM_READER_GAIN_EN
  logic [DW+15:0] product;
  logic [DW+15:0] scaled;

  assign product = bus.dout_i * cfg_gain_i;
  assign scaled  = product >> 8;
  assign sample_d = (|scaled[DW+15:DW]) ? {DW{1'b1}} : scaled[DW-1:0];
`else
  assign sample_d = bus.dout_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      if (state_q == REQ) begin
        addr_q <= ptr;
      end

      // Disable drops any pending sample; otherwise valid rises on capture and
      // falls only on the handshake.
      if (!cfg_en_i) begin
        tvalid_q <= 1'b0;
      end else if (state_q == WAIT) begin
        tvalid_q <= 1'b1;
        tdata_q  <= sample_d;
      end else if (state_q == HOLD && handshake) begin
        tvalid_q <= 1'b0;
      end
    end
  end

endmodule : stim_mem_reader

// File: tb/tb_stim_mem_reader.sv
// Directed bench for stim_mem_reader: banked one-cycle-latency memory model
// and hand-computed expected samples.
module tb_stim_mem_reader;
  import stim_mem_reader_pkg::*;

  localparam int AW   = AW_DEF;
  localparam int DW   = DW_DEF;
  localparam int INCW = INCW_DEF;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            cfg_en    = 1'b0;
  logic [AW-1:0]   cfg_start = '0;
  logic [AW-1:0]   cfg_end   = '0;
  logic [INCW-1:0] cfg_inc   = '0;
`ifdef STIM_MEM_READER_GAIN_EN
  logic [15:0]     cfg_gain  = UNITY_GAIN;
`endif

  stim_mem_reader_if #(.AW(AW), .DW(DW)) bus ();

  stim_mem_reader #(.AW(AW), .DW(DW), .INCW(INCW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_en_i    (cfg_en),
    .cfg_start_i (cfg_start),
    .cfg_end_i   (cfg_end),
    .cfg_inc_i   (cfg_inc),
`ifdef STIM_MEM_READER_GAIN_EN
    .cfg_gain_i  (cfg_gain),
`endif
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two SRAM banks with registered read data; dout is muxed by the live address
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] bank0_q = '0;
  logic [DW-1:0] bank1_q = '0;

  always @(posedge clk) begin
    if (!bus.csb_o) begin
      if (bus.addr_o[AW-1]) bank1_q <= mem[bus.addr_o];
      else                  bank0_q <= mem[bus.addr_o];
    end
  end

  assign bus.dout_i = bus.addr_o[AW-1] ? bank1_q : bank0_q;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int last_req = 0;

  // Follows one REQ/WAIT/HOLD sequence, sampling on falling edges
  task automatic expect_sample(input string tag, input logic [AW-1:0] exp_addr,
                               input logic [DW-1:0] exp_data, input bit chk_gap);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !bus.csb_o;
    end
    check({tag, " req seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " req addr"}, 32'(bus.addr_o), 32'(exp_addr));
      if (chk_gap) check({tag, " period"}, 32'(cyc - last_req), 32'd3);
      last_req = cyc;
      @(negedge clk);
      check({tag, " wait csb"}, 32'(bus.csb_o), 32'd1);
      check({tag, " wait addr"}, 32'(bus.addr_o), 32'(exp_addr));
      @(negedge clk);
      check({tag, " valid"}, 32'(bus.tvalid_o), 32'd1);
      check({tag, " data"}, bus.tdata_o, exp_data);
    end
  endtask

  task automatic stop_run();
    @(negedge clk);
    cfg_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " csb"},    32'(bus.csb_o),    32'd1);
    check({tag, " addr"},   32'(bus.addr_o),   32'd0);
    check({tag, " tvalid"}, 32'(bus.tvalid_o), 32'd0);
    check({tag, " tdata"},  bus.tdata_o,       32'd0);
    check({tag, " busy"},   32'(bus.busy_o),   32'd0);
  endtask

  logic [DW-1:0] exp_gain_a, exp_gain_b;

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);
    mem[0] = 32'hDEAD_BEEF;
    mem[1] = 32'h1234_5678;
    mem[2] = 32'hA5A5_0F0F;
    mem[3] = 32'h0000_0001;
    mem[10'h100] = 32'h0000_1000;
    mem[10'h101] = 32'hFFFF_0000;
    bus.tready_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic window 0..3, tready high: 3-cycle cadence and wrap to start
    cfg_start = 10'h000; cfg_end = 10'h003; cfg_inc = 8'd1; cfg_en = 1'b1;
    expect_sample("w0 s0", 10'h000, 32'hDEAD_BEEF, 1'b0);
    expect_sample("w0 s1", 10'h001, 32'h1234_5678, 1'b1);
    expect_sample("w0 s2", 10'h002, 32'hA5A5_0F0F, 1'b1);
    expect_sample("w0 s3", 10'h003, 32'h0000_0001, 1'b1);
    expect_sample("w0 s4", 10'h000, 32'hDEAD_BEEF, 1'b1);
    expect_sample("w0 s5", 10'h001, 32'h1234_5678, 1'b1);

    // Bank crossing 0x1FE..0x201
    stop_run();
    cfg_start = 10'h1FE; cfg_end = 10'h201; cfg_en = 1'b1;
    expect_sample("bank s0", 10'h1FE, 32'h0000_01FE, 1'b0);
    expect_sample("bank s1", 10'h1FF, 32'h0000_01FF, 1'b1);
    expect_sample("bank s2", 10'h200, 32'h0000_0200, 1'b1);
    expect_sample("bank s3", 10'h201, 32'h0000_0201, 1'b1);
    expect_sample("bank s4", 10'h1FE, 32'h0000_01FE, 1'b1);

    // Backpressure: 10 cycles stalled in HOLD
    stop_run();
    bus.tready_i = 1'b0;
    cfg_start = 10'h040; cfg_end = 10'h043; cfg_en = 1'b1;
    expect_sample("bp", 10'h040, 32'h0000_0040, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp hold valid", 32'(bus.tvalid_o), 32'd1);
      check("bp hold data",  bus.tdata_o,       32'h0000_0040);
      check("bp hold addr",  32'(bus.addr_o),   32'h040);
      check("bp hold csb",   32'(bus.csb_o),    32'd1);
    end
    bus.tready_i = 1'b1;
    @(negedge clk);
    check("bp next csb",    32'(bus.csb_o),    32'd0);
    check("bp next addr",   32'(bus.addr_o),   32'h041);
    check("bp next tvalid", 32'(bus.tvalid_o), 32'd0);

    // Step 6 in 0x10..0x1F, then inc 0, then start above end
    stop_run();
    cfg_start = 10'h010; cfg_end = 10'h01F; cfg_inc = 8'd6; cfg_en = 1'b1;
    expect_sample("inc6 s0", 10'h010, 32'h0000_0010, 1'b0);
    expect_sample("inc6 s1", 10'h016, 32'h0000_0016, 1'b1);
    expect_sample("inc6 s2", 10'h01C, 32'h0000_001C, 1'b1);
    expect_sample("inc6 s3", 10'h010, 32'h0000_0010, 1'b1);
    stop_run();
    cfg_inc = 8'd0; cfg_en = 1'b1;
    for (int i = 0; i < 3; i++) expect_sample("inc0", 10'h010, 32'h0000_0010, 1'b0);
    stop_run();
    cfg_start = 10'h020; cfg_end = 10'h010; cfg_inc = 8'd1; cfg_en = 1'b1;
    for (int i = 0; i < 3; i++) expect_sample("inverted", 10'h020, 32'h0000_0020, 1'b0);

    // Disable during WAIT, re-enable after 3 cycles
    stop_run();
    cfg_start = 10'h030; cfg_end = 10'h03F; cfg_en = 1'b1;
    @(negedge clk);
    check("dis req csb",  32'(bus.csb_o),  32'd0);
    check("dis req addr", 32'(bus.addr_o), 32'h030);
    @(negedge clk);
    check("dis in wait csb", 32'(bus.csb_o), 32'd1);
    cfg_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dis idle busy",   32'(bus.busy_o),   32'd0);
      check("dis idle tvalid", 32'(bus.tvalid_o), 32'd0);
      check("dis idle csb",    32'(bus.csb_o),    32'd1);
    end
    cfg_en = 1'b1;
    expect_sample("reenable", 10'h030, 32'h0000_0030, 1'b0);

    // Async reset while holding a sample
    bus.tready_i = 1'b0;
    @(negedge clk);
    check("pre rst tvalid", 32'(bus.tvalid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async rst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("in rst csb", 32'(bus.csb_o), 32'd1);
    end
    rst_n = 1'b0;
    bus.tready_i = 1'b1;
    rst_n = 1'b1;
    expect_sample("post rst", 10'h030, 32'h0000_0030, 1'b0);

    // Gain stage (raw data when the gain feature is not built)
`ifdef STIM_MEM_READER_GAIN_EN
    exp_gain_a = 32'h0000_1800;
    exp_gain_b = 32'hFFFF_FFFF;
`else
    exp_gain_a = 32'h0000_1000;
    exp_gain_b = 32'hFFFF_0000;
`endif
    stop_run();
`ifdef STIM_MEM_READER_GAIN_EN
    cfg_gain = 16'h0180;
`endif
    cfg_start = 10'h100; cfg_end = 10'h100; cfg_en = 1'b1;
    expect_sample("gain 1.5", 10'h100, exp_gain_a, 1'b0);
    stop_run();
`ifdef STIM_MEM_READER_GAIN_EN
    cfg_gain = 16'h0200;
`endif
    cfg_start = 10'h101; cfg_end = 10'h101; cfg_en = 1'b1;
    expect_sample("gain sat", 10'h101, exp_gain_b, 1'b0);

    stop_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_stim_mem_reader

// File: doc/stim_mem_reader.md
Name: stim_mem_reader

Overview:
- Sequential read master for the merged 1024x32 stimulus memory: the memory-merge stage's csb/addr/dout port.
- Walks a configured address window and returns the read words as a valid/ready sample stream to the waveform generator core.
- Loops continuously while enabled.
- Hides the one-cycle SRAM read latency and the merge stage's combinational dout bank select.

Parameters:
- AW, 10, memory word-address width (addr[AW-1] selects the bank in the merge stage)
- DW, 32, data width of memory words and output samples
- INCW, 8, width of the address increment

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_en_i  in  1  run enable; level sensitive
- cfg_start_i  in  AW  first address of the window
- cfg_end_i  in  AW  last address of the window, inclusive
- cfg_inc_i  in  INCW  address step per sample
- csb_o  out  1  memory chip select, active low
- addr_o  out  AW  memory word address
- dout_i  in  DW  memory read data, valid the cycle after csb_o low is sampled
- tvalid_o  out  1  output sample valid
- tready_i  in  1  downstream ready
- tdata_o  out  DW  output sample
- busy_o  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, rst_n low):
  - csb_o=1, addr_o=0, tvalid_o=0, tdata_o=0, busy_o=0.
  - FSM=IDLE, address pointer=0.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - csb_o=1.
  - When cfg_en_i=1: load pointer <= cfg_start_i, go to REQ.
- REQ (1 cycle):
  - csb_o=0, addr_o=pointer; then go to WAIT.
- WAIT (1 cycle):
  - csb_o=1, addr_o held at the same value. This is mandatory: the merge stage muxes dout by the current addr[AW-1].
  - At the end of the cycle: tdata_o <= dout_i, tvalid_o <= 1, pointer <= next; go to HOLD.
- HOLD:
  - tvalid_o=1; tdata_o and addr_o stable until the handshake.
  - On tvalid_o & tready_i: tvalid_o <= 0 and go to REQ.
  - Throughput: one sample per 3 cycles with tready_i tied high.
- Next-address rule, computed at AW+1 bits:
  - sum = pointer + cfg_inc_i.
  - If sum > cfg_end_i, or pointer >= cfg_end_i, then next = cfg_start_i; else next = sum[AW-1:0].
- Boundaries:
  - cfg_inc_i=0: repeats the same address.
  - cfg_start_i > cfg_end_i: every read is at cfg_start_i.
  - Window crossing 0x1FF->0x200 (bank change): no special handling; the held addr guarantees the correct bank data.
  - Address never wraps past 2^AW-1; the inclusive end check applies.
- Config changes while running:
  - cfg_* changes take effect at the next pointer update.
  - cfg_start_i is reloaded only on wrap or on entry from IDLE.
- cfg_en_i=0 in any state: next cycle goes to IDLE with csb_o=1 and tvalid_o=0.
  - A pending sample is dropped. This is permitted and is the only case where tvalid_o falls without a handshake.
  - Re-enable restarts at cfg_start_i.
- Reset mid-operation: immediate return to reset values; no memory access is issued.
- csb_o is low for exactly one cycle per sample and is never low in WAIT, HOLD or IDLE.

Optional Feature:
- Macro: STIM_MEM_READER_GAIN_EN.
- Defined:
  - Extra port cfg_gain_i, in, 16, unsigned gain in 8.8 format (0x0100 = unity).
  - The WAIT capture stores tdata_o <= min((dout_i * cfg_gain_i) >> 8, 2^DW-1), unsigned, saturating.
  - The 48-bit product is computed combinationally; latency is unchanged.
- Undefined: no cfg_gain_i port; tdata_o <= dout_i unchanged.

Decomposition:
- stim_mem_reader_pkg holds:
  - state enum type (IDLE, REQ, WAIT, HOLD)
  - default AW/DW/INCW localparams
  - the unity-gain constant 16'h0100
- Sub-module stim_mem_addr_gen: pointer register plus the next-address/wrap rule.
  - Inputs: load, advance, start/end/inc.
  - Output: pointer.

Test Plan:
- Reset, then start=0x000, end=0x003, inc=1, tready=1 -> csb_o low pulses at addr 0,1,2,3,0,1...; samples equal memory contents; one sample per 3 cycles.
- Bank crossing: start=0x1FE, end=0x201, inc=1, memory word = address pattern -> tdata 0x1FE,0x1FF,0x200,0x201,0x1FE; addr_o equals the captured address during each WAIT.
- Backpressure: tready=0 for 10 cycles in HOLD -> tvalid_o stays 1, tdata_o and addr_o stable, no csb_o pulse; after the handshake the next read is issued 1 cycle later.
- Wrap and step: start=0x010, end=0x01F, inc=6 -> addresses 0x010,0x016,0x01C,0x010; inc=0 -> 0x010 repeated; start=0x020, end=0x010 -> always 0x020.
- Mid-run disable in WAIT, then re-enable after 3 cycles -> IDLE next cycle, tvalid_o=0, csb_o=1; restart reads cfg_start_i. Async rst_n pulse in HOLD -> all outputs return to reset values immediately.
- With STIM_MEM_READER_GAIN_EN:
  - dout=0x0000_1000, gain=0x0180 -> tdata 0x0000_1800.
  - dout=0xFFFF_0000, gain=0x0200 -> tdata 0xFFFF_FFFF (saturated).
